// File: rtl/frame_io_pkg.sv
// Definitions shared by the frame input (write side) and line output (read side) controllers.
package frame_io_pkg;

    localparam int LEN_W = 16;

    // The 3-bit width matches the output controller's state register.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        TRACE    = 3'd2,
        RETRACE  = 3'd3
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain plus edge register: a one-cycle edge pulse on a slow asynchronous level.
// RISING selects a rising-edge pulse (1) or a falling-edge pulse (0).
module edge_sync #(
    parameter int STAGES = 2,
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_edge
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_d);
            r_prev <= w_level;
        end
    end

    assign w_level = r_sync[STAGES-1];
    assign o_edge  = RISING ? (w_level & ~r_prev) : (~w_level & r_prev);

endmodule

// File: rtl/frame_input_con.sv
// Write-side line capture: packs two samples per FIFO word and writes only the trace part of each line.
// Build option TEST_PATTERN_EN replaces the sample input with an internal incrementing counter.
module frame_input_con
    import frame_io_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_enable,
    input  logic              i_update_flag,
    input  logic [LEN_W-1:0]  i_trace_length,
    input  logic [LEN_W-1:0]  i_retrace_length,
    input  logic              i_sof,
    input  logic              i_din_valid,
    input  logic [DW-1:0]     i_din,
    input  logic              i_fifo_full,
    input  logic [AW-1:0]     i_fifo_usedw,
    output logic              o_fifo_wreq,
    output logic [2*DW-1:0]   o_fifo_data,
    output logic              o_fifo_ready,
    output logic              o_line_done,
    output logic              o_overflow,
    output state_t            o_state
);

    logic w_sof_rise;
    logic w_upd_fall;
    logic [DW-1:0] w_din;
    logic w_unused;

    state_t             r_state, w_state_n;
    logic [LEN_W-1:0]   r_word_cnt, w_word_cnt_n;
    logic [LEN_W-1:0]   r_rcnt, w_rcnt_n;
    logic               r_half, w_half_n;
    logic [DW-1:0]      r_low, w_low_n;
    logic [2*DW-1:0]    r_data, w_data_n;
    logic               r_wreq, w_wreq_n;
    logic               r_line_done, w_line_done_n;
    logic               r_overflow, w_overflow_n;
    logic [LEN_W-1:0]   r_trace_words;
    logic [LEN_W-1:0]   r_retrace;
    logic               r_ready;
    logic [LEN_W-1:0]   w_word_inc, w_rcnt_inc;

    edge_sync #(.STAGES(2), .RISING(1'b1)) u_sof_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (i_sof),
        .o_edge  (w_sof_rise)
    );

    // Single stage pair (f0, f1): lengths are taken on the falling edge of the strobe.
    edge_sync #(.STAGES(1), .RISING(1'b0)) u_upd_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (i_update_flag),
        .o_edge  (w_upd_fall)
    );

    assign w_unused = ^{i_trace_length[0], i_din};

`ifdef TEST_PATTERN_EN
    logic [DW-1:0] r_tp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tp <= '0;
        end else if (w_sof_rise) begin
            r_tp <= '0;
        end else if (i_enable && i_din_valid && (r_state == TRACE || r_state == RETRACE)) begin
            r_tp <= r_tp + DW'(1);
        end
    end

    assign w_din = r_tp;
`else
    assign w_din = i_din;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trace_words <= '0;
            r_retrace     <= '0;
            r_ready       <= 1'b0;
        end else begin
            if (w_upd_fall) begin
                r_trace_words <= {1'b0, i_trace_length[LEN_W-1:1]};
                r_retrace     <= i_retrace_length;
            end
            r_ready <= (LEN_W'(i_fifo_usedw) >= r_trace_words) && (r_trace_words != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_word_cnt  <= '0;
            r_rcnt      <= '0;
            r_half      <= 1'b0;
            r_low       <= '0;
            r_data      <= '0;
            r_wreq      <= 1'b0;
            r_line_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_word_cnt  <= w_word_cnt_n;
            r_rcnt      <= w_rcnt_n;
            r_half      <= w_half_n;
            r_low       <= w_low_n;
            r_data      <= w_data_n;
            r_wreq      <= w_wreq_n;
            r_line_done <= w_line_done_n;
            r_overflow  <= w_overflow_n;
        end
    end

    assign w_word_inc = r_word_cnt + LEN_W'(1);
    assign w_rcnt_inc = r_rcnt + LEN_W'(1);

    always_comb begin
        w_state_n     = r_state;
        w_word_cnt_n  = r_word_cnt;
        w_rcnt_n      = r_rcnt;
        w_half_n      = r_half;
        w_low_n       = r_low;
        w_data_n      = r_data;
        w_wreq_n      = 1'b0;
        w_line_done_n = 1'b0;
        w_overflow_n  = w_upd_fall ? 1'b0 : r_overflow;

        if (!i_enable) begin
            w_state_n    = IDLE;
            w_word_cnt_n = '0;
            w_rcnt_n     = '0;
            w_half_n     = 1'b0;
            w_overflow_n = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_trace_words != '0) w_state_n = WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (w_sof_rise) begin
                        w_state_n    = TRACE;
                        w_word_cnt_n = '0;
                        w_half_n     = 1'b0;
                    end
                end
                TRACE: begin
                    if (w_sof_rise) begin
                        w_word_cnt_n = '0;
                        w_rcnt_n     = '0;
                        w_half_n     = 1'b0;
                    end else if (i_din_valid) begin
                        if (!r_half) begin
                            w_low_n  = w_din;
                            w_half_n = 1'b1;
                        end else begin
                            w_half_n     = 1'b0;
                            w_data_n     = {w_din, r_low};
                            w_word_cnt_n = w_word_inc;
                            // A dropped word still counts so line geometry stays intact.
                            if (i_fifo_full) w_overflow_n = 1'b1;
                            else             w_wreq_n     = 1'b1;
                            if (w_word_inc >= r_trace_words) begin
                                w_line_done_n = 1'b1;
                                w_word_cnt_n  = '0;
                                if (r_retrace != '0) begin
                                    w_state_n = RETRACE;
                                    w_rcnt_n  = '0;
                                end
                            end
                        end
                    end
                end
                RETRACE: begin
                    if (w_sof_rise) begin
                        w_state_n    = TRACE;
                        w_word_cnt_n = '0;
                        w_rcnt_n     = '0;
                        w_half_n     = 1'b0;
                    end else if (i_din_valid) begin
                        w_rcnt_n = w_rcnt_inc;
                        if (w_rcnt_inc >= r_retrace) begin
                            w_state_n    = TRACE;
                            w_word_cnt_n = '0;
                            w_half_n     = 1'b0;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    assign o_fifo_wreq  = r_wreq;
    assign o_fifo_data  = r_data;
    assign o_fifo_ready = r_ready;
    assign o_line_done  = r_line_done;
    assign o_overflow   = r_overflow;
    assign o_state      = r_state;

endmodule

// File: tb/tb_frame_input_con.sv
// Bench for frame_input_con: directed scenarios plus randomized frames against a line-position model.
module tb_frame_input_con;

    localparam int DW = 16;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              update_flag = 1'b0;
    logic [15:0]       trace_length = '0;
    logic [15:0]       retrace_length = '0;
    logic              sof = 1'b0;
    logic              din_valid = 1'b0;
    logic [DW-1:0]     din = '0;
    logic              fifo_full = 1'b0;
    logic [AW-1:0]     fifo_usedw = '0;
    logic              fifo_wreq;
    logic [2*DW-1:0]   fifo_data;
    logic              fifo_ready;
    logic              line_done;
    logic              overflow;
    frame_io_pkg::state_t st;

    frame_input_con #(.DW(DW), .AW(AW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_enable         (enable),
        .i_update_flag    (update_flag),
        .i_trace_length   (trace_length),
        .i_retrace_length (retrace_length),
        .i_sof            (sof),
        .i_din_valid      (din_valid),
        .i_din            (din),
        .i_fifo_full      (fifo_full),
        .i_fifo_usedw     (fifo_usedw),
        .o_fifo_wreq      (fifo_wreq),
        .o_fifo_data      (fifo_data),
        .o_fifo_ready     (fifo_ready),
        .o_line_done      (line_done),
        .o_overflow       (overflow),
        .o_state          (st)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard
    logic [2*DW-1:0] exp_q[$];
    int wr_seen = 0;
    int ld_seen = 0;

    always @(negedge clk) begin
        if (reset_n && fifo_wreq) begin
            wr_seen++;
            check("wr_pending", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) check("wr_data", fifo_data, exp_q.pop_front());
        end
        if (reset_n && line_done) ld_seen++;
    end

    // reference model: position of each sample within the trace+retrace period since sof
    int unsigned m_words = 0;
    int unsigned m_retr = 0;
    int unsigned m_k = 0;
    logic [DW-1:0] m_prev = '0;
    int ld_exp = 0;
    logic ovf_exp = 1'b0;

    task automatic model_sample(input logic [DW-1:0] d, input logic full);
        int unsigned period, p;
        period = 2 * m_words + m_retr;
        p = m_k % period;
        if (p < 2 * m_words && (p % 2) == 1) begin
            if (full) ovf_exp = 1'b1;
            else      exp_q.push_back({d, m_prev});
            if (p == 2 * m_words - 1) ld_exp++;
        end
        m_prev = d;
        m_k++;
    endtask

    // drivers
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic full, input bit counted);
        din_valid = 1'b1;
        din = d;
        fifo_full = full;
        if (counted) model_sample(d, full);
        tick(1);
        din_valid = 1'b0;
        fifo_full = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    task automatic cfg(input int tl, input int rl);
        trace_length = 16'(tl);
        retrace_length = 16'(rl);
        update_flag = 1'b1;
        tick(2);
        update_flag = 1'b0;
        tick(3);
        m_words = 32'(tl) >> 1;
        m_retr = 32'(rl);
        ovf_exp = 1'b0;
    endtask

    // pre: samples sent while the sof edge is still pending; they must be ignored
    task automatic start_frame(input int pre);
        sof = 1'b0;
        tick(4);
        repeat (pre) send(16'($urandom), 1'b0, 1'b0);
        sof = 1'b1;
        tick(5);
        m_k = 0;
    endtask

    task automatic finish_chk(input string tag);
        tick(4);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'(0));
        check({tag, "_line_done"}, 32'(ld_seen), 32'(ld_exp));
        check({tag, "_overflow"}, 32'(overflow), 32'(ovf_exp));
    endtask

    int wr0, ld0;

    initial begin
        tick(3);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_wreq", 32'(fifo_wreq), 32'(0));
        check("rst_data", fifo_data, 32'(0));
        check("rst_ready", 32'(fifo_ready), 32'(0));
        check("rst_line_done", 32'(line_done), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_state", 32'(st), 32'(0));
        @(posedge clk);
        #1;
        enable = 1'b1;
        tick(3);
        check("idle_no_length", 32'(st), 32'(0));

        // directed: 8/4, samples 0..11
        cfg(8, 4);
        check("t1_wait_sof", 32'(st), 32'(1));
        start_frame(2);
        check("t1_trace", 32'(st), 32'(2));
        wr0 = wr_seen;
        ld0 = ld_seen;
        for (int i = 0; i < 12; i++) send(16'(i), 1'b0, 1'b1);
        finish_chk("t1");
        check("t1_writes", 32'(wr_seen - wr0), 32'(4));
        check("t1_lines", 32'(ld_seen - ld0), 32'(1));

        // no retrace: 4/0, 12 samples
        cfg(4, 0);
        start_frame(0);
        wr0 = wr_seen;
        ld0 = ld_seen;
        for (int i = 0; i < 12; i++) send(16'($urandom), 1'b0, 1'b1);
        finish_chk("t2");
        check("t2_writes", 32'(wr_seen - wr0), 32'(6));
        check("t2_lines", 32'(ld_seen - ld0), 32'(3));

        // FIFO full on the second word
        cfg(8, 4);
        start_frame(0);
        for (int i = 0; i < 4; i++) send(16'($urandom), 1'(i == 3), 1'b1);
        finish_chk("t3");
        tick(10);
        check("t3_ovf_sticky", 32'(overflow), 32'(1));
        cfg(8, 4);
        check("t3_ovf_cleared", 32'(overflow), 32'(0));

        // fifo_ready threshold with 3 words per line
        cfg(6, 0);
        fifo_usedw = 10'd2;
        tick(2);
        @(negedge clk);
        check("t4_ready_below", 32'(fifo_ready), 32'(0));
        @(posedge clk);
        #1;
        fifo_usedw = 10'd3;
        @(negedge clk);
        check("t4_ready_same_cycle", 32'(fifo_ready), 32'(0));
        @(negedge clk);
        check("t4_ready_next_cycle", 32'(fifo_ready), 32'(1));
        @(posedge clk);
        #1;
        fifo_usedw = '0;

        // enable drop mid-trace leaves no stale half word
        cfg(8, 4);
        start_frame(0);
        for (int i = 0; i < 3; i++) send(16'($urandom), 1'b0, 1'b1);
        tick(1);
        enable = 1'b0;
        ovf_exp = 1'b0;
        tick(3);
        check("t5_idle", 32'(st), 32'(0));
        enable = 1'b1;
        start_frame(1);
        for (int i = 0; i < 4; i++) send(16'($urandom), 1'b0, 1'b1);
        finish_chk("t5");

        // odd trace length: 7 -> 3 words, 7th sample starts retrace
        cfg(7, 2);
        start_frame(0);
        wr0 = wr_seen;
        ld0 = ld_seen;
        for (int i = 0; i < 14; i++) send(16'($urandom), 1'b0, 1'b1);
        finish_chk("t6");
        check("t6_writes", 32'(wr_seen - wr0), 32'(6));
        check("t6_lines", 32'(ld_seen - ld0), 32'(2));

        // randomized frames, sometimes with FIFO full
        for (int r = 0; r < 8; r++) begin
            int tl, rl, n;
            tl = $urandom_range(2, 12);
            rl = $urandom_range(0, 5);
            n = $urandom_range(4, 30);
            cfg(tl, rl);
            start_frame(0);
            for (int i = 0; i < n; i++) send(16'($urandom), 1'($urandom_range(0, 7) == 0), 1'b1);
            finish_chk($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        n_mis++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/frame_input_con.md
Name: frame_input_con

Overview:
- Write-side counterpart of the line-output controller; captures the incoming sample stream into the shared line FIFO.
- Packs two DW-bit samples per FIFO word and writes only the trace (active) portion of each line; retrace samples are counted and discarded.
- Raises fifo_ready once at least one full line is buffered. The reader uses fifo_ready to pace trace/retrace readout.

Parameters:
- DW, 16, sample width; FIFO word width = 2*DW
- AW, 10, width of FIFO used-words count

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  capture enable; low forces IDLE and clears counters
- update_flag  in  1  config update strobe; lengths latched on its falling edge
- trace_length  in  16  active samples per line; LSB ignored (word count = trace_length[15:1])
- retrace_length  in  16  samples to discard after each trace
- sof  in  1  frame start, asynchronous level
- din_valid  in  1  sample qualifier
- din  in  DW  sample
- fifo_full  in  1  FIFO full flag
- fifo_usedw  in  AW  FIFO used-word count
- fifo_wreq  out  1  FIFO write request
- fifo_data  out  2*DW  packed word, {second sample, first sample}
- fifo_ready  out  1  at least one line buffered
- line_done  out  1  one-cycle pulse at end of each trace
- overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0; state IDLE; trace_words_reg = 0; retrace_reg = 0; counters = 0.
- update_flag is registered twice (f0, f1). On !f0 & f1:
  - trace_words_reg <= {1'b0, trace_length[15:1]}
  - retrace_reg <= retrace_length
  - overflow cleared
- sof passes through a 2-flop synchronizer plus an edge register. Its rising edge is seen 3 cycles after the input transition.
- enable low (synchronous, highest priority below reset):
  - state <= IDLE; counters, half-word flag and fifo_wreq cleared; line_done = 0.
  - overflow cleared. Lengths are kept.
- States:
  - IDLE: go to WAIT_SOF when enable = 1 and trace_words_reg != 0.
  - WAIT_SOF: on sof rising edge go to TRACE with word_cnt = 0 and half = 0.
  - TRACE, on each din_valid:
    - half = 0: store din in the low half; set half = 1.
    - half = 1: drive fifo_data = {din, low}. Assert fifo_wreq for exactly 1 cycle (registered; write occurs the cycle after the second sample) unless fifo_full, in which case there is no write and overflow is set. word_cnt++ in both cases.
    - When word_cnt reaches trace_words_reg: pulse line_done. If retrace_reg != 0, go to RETRACE with rcnt = 0; otherwise stay in TRACE with word_cnt = 0.
  - RETRACE: rcnt++ on each din_valid. After retrace_reg samples, go to TRACE with word_cnt = 0 and half = 0. No writes occur.
- A sof rising edge while in TRACE or RETRACE resynchronises: go to TRACE with counters and half cleared. A partially packed word is discarded.
- fifo_ready is registered: 1 when fifo_usedw >= trace_words_reg (zero-extended to 16 bits) and trace_words_reg != 0; else 0.
- din_valid with no sof seen yet (IDLE or WAIT_SOF): samples are ignored.
- A length update mid-frame takes effect at the next comparison. The engineer must not rely on this; software updates only between frames.
- Counters are 16-bit with no wrap in normal operation, since they are bounded by the registered lengths.

Optional Feature:
- TEST_PATTERN_EN
  - Defined: din is replaced internally by a DW-bit incrementing counter. The counter advances on each accepted din_valid and is reset to 0 on sof edge. Line structure and timing are unchanged.
  - Undefined: din is used directly; the counter logic is absent.

Decomposition:
- Shared package frame_io_pkg holds:
  - state encoding constants IDLE = 0, WAIT_SOF = 1, TRACE = 2, RETRACE = 3 (3-bit, matching the output controller's width)
  - LEN_W = 16
- One natural sub-module: edge_sync. Its parameter is STAGES; it provides the sof synchronizer and rising-edge pulse, and is reusable for update_flag edge detection.

Test Plan:
- trace_length = 8, retrace_length = 4, sof edge, then 12 valid samples 0..11 -> 4 writes: 0x0001_0000, 0x0003_0002, 0x0005_0004, 0x0007_0006. line_done pulses once; samples 8..11 are not written.
- retrace_length = 0, trace_length = 4, 12 samples -> 6 writes, line_done pulses 3 times, no gaps.
- fifo_full held high for the second packed word -> that write is suppressed, overflow = 1 and stays 1 until the update_flag falling edge.
- trace_length = 6, fifo_usedw stepped 2 -> 3 -> fifo_ready goes 0 -> 1 one cycle after usedw = 3.
- enable deasserted after 3 samples of a trace, then re-enabled with a new sof -> first write after re-enable contains only post-sof samples, with no stale half word.
- trace_length = 7 -> 3 words written per line; the 7th sample is counted as the first retrace sample.
